// File: rtl/parallel_divider_array.sv
// Multi-lane radix-2 restoring divider: CHANNELS numerators share one denominator, WIDTH+1 cycles.
// Define PARALLEL_DIVIDER_SIGNED_EN for two's-complement operands (truncating quotient).
module parallel_divider_array #(
   parameter int unsigned WIDTH    = 40,
   parameter int unsigned CHANNELS = 11
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clken,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            den,
   input  logic [WIDTH*CHANNELS-1:0]   num,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH*CHANNELS-1:0]   quot,
   output logic [WIDTH*CHANNELS-1:0]   remain,
   output logic                        div_zero
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     den_q;
   logic                 den_zero_q;
   logic [WIDTH-1:0]     rem_q    [CHANNELS];
   logic [WIDTH-1:0]     shf_q    [CHANNELS];
   logic [WIDTH-1:0]     rem_d    [CHANNELS];
   logic [WIDTH-1:0]     shf_d    [CHANNELS];
   logic [WIDTH:0]       trial    [CHANNELS];
   logic [CHANNELS-1:0]  geq;
   logic [WIDTH-1:0]     fin_quot [CHANNELS];
   logic [WIDTH-1:0]     fin_rem  [CHANNELS];
`ifdef PARALLEL_DIVIDER_SIGNED_EN
   logic                 den_neg_q;
   logic [CHANNELS-1:0]  num_neg_q;
`endif

   // Operand magnitude; identity in the unsigned build.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
`ifdef PARALLEL_DIVIDER_SIGNED_EN
      return x[WIDTH-1] ? -x : x;
`else
      return x;
`endif
   endfunction

   assign in_ready = (state_q == StIdle);

   // shf_q holds the unconsumed numerator bits on top and grows the quotient at the bottom.
   always_comb begin
      geq = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         trial[k]    = {rem_q[k], shf_q[k][WIDTH-1]};
         geq[k]      = trial[k] >= {1'b0, den_q};
         rem_d[k]    = geq[k] ? WIDTH'(trial[k] - {1'b0, den_q}) : trial[k][WIDTH-1:0];
         shf_d[k]    = {shf_q[k][WIDTH-2:0], geq[k]};
`ifdef PARALLEL_DIVIDER_SIGNED_EN
         fin_quot[k] = (num_neg_q[k] ^ den_neg_q) ? -shf_q[k] : shf_q[k];
         fin_rem[k]  = num_neg_q[k] ? -rem_q[k] : rem_q[k];
`else
         fin_quot[k] = shf_q[k];
         fin_rem[k]  = rem_q[k];
`endif
         if (den_zero_q) begin
            fin_quot[k] = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         den_q      <= '0;
         den_zero_q <= 1'b0;
         out_valid  <= 1'b0;
         div_zero   <= 1'b0;
         quot       <= '0;
         remain     <= '0;
`ifdef PARALLEL_DIVIDER_SIGNED_EN
         den_neg_q  <= 1'b0;
         num_neg_q  <= '0;
`endif
         for (int k = 0; k < CHANNELS; k++) begin
            rem_q[k] <= '0;
            shf_q[k] <= '0;
         end
      end else if (clken) begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  den_q      <= mag(den);
                  den_zero_q <= (den == '0);
                  cnt_q      <= CW'(WIDTH - 1);
`ifdef PARALLEL_DIVIDER_SIGNED_EN
                  den_neg_q  <= den[WIDTH-1];
`endif
                  for (int k = 0; k < CHANNELS; k++) begin
                     rem_q[k] <= '0;
                     shf_q[k] <= mag(num[k*WIDTH +: WIDTH]);
`ifdef PARALLEL_DIVIDER_SIGNED_EN
                     num_neg_q[k] <= num[k*WIDTH + WIDTH - 1];
`endif
                  end
                  state_q <= StRun;
               end
            end
            StRun: begin
               for (int k = 0; k < CHANNELS; k++) begin
                  rem_q[k] <= rem_d[k];
                  shf_q[k] <= shf_d[k];
               end
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               // First DONE cycle applies sign/zero fix-up into the output registers.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  div_zero  <= den_zero_q;
                  for (int k = 0; k < CHANNELS; k++) begin
                     quot[k*WIDTH +: WIDTH]   <= fin_quot[k];
                     remain[k*WIDTH +: WIDTH] <= fin_rem[k];
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_parallel_divider_array.sv
// Directed + randomized bench for parallel_divider_array against an arithmetic reference model.
// Honours PARALLEL_DIVIDER_SIGNED_EN to select the signed reference model and signed vectors.
module tb_parallel_divider_array;

   localparam int W = 40;
   localparam int C = 11;

   logic               clk = 1'b0;
   logic               reset, clken, in_valid, in_ready, out_valid, out_ready, div_zero;
   logic [W-1:0]       den;
   logic [W*C-1:0]     num, quot, remain;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [W*C-1:0] last_quot, last_rem;
   logic           last_zero;

   parallel_divider_array #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .clken     (clken),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .den       (den),
      .num       (num),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .remain    (remain),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_w();
      logic [63:0] t;
      t = {$urandom, $urandom};
      return t[W-1:0];
   endfunction

   function automatic void model(input logic [W-1:0] n, input logic [W-1:0] d,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef PARALLEL_DIVIDER_SIGNED_EN
      logic signed [W-1:0] ns, ds;
      longint sn, sd;
`endif
      if (d == '0) begin
         q = '1;
         r = n;
      end else begin
`ifdef PARALLEL_DIVIDER_SIGNED_EN
         ns = n;
         ds = d;
         sn = ns;
         sd = ds;
         q  = W'(sn / sd);
         r  = W'(sn % sd);
`else
         q = n / d;
         r = n % d;
`endif
      end
   endfunction

   // gap_mode: 0 clken high, 1 random clken, 2 clken low on edges 11..13 after accept.
   task automatic do_req(input string tag, input logic [W-1:0] d, input logic [W*C-1:0] n,
                         input int gap_mode, input int bp);
      logic [W*C-1:0] eq, er;
      logic [W-1:0]   q, r;
      int             tot, en_edges;
      logic           seen;
      for (int k = 0; k < C; k++) begin
         model(n[k*W +: W], d, q, r);
         eq[k*W +: W] = q;
         er[k*W +: W] = r;
      end
      check({tag, " ready_before"}, 64'(in_ready), 64'd1);
      den = d;
      num = n;
      in_valid = 1'b1;
      clken = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " ready_after_accept"}, 64'(in_ready), 64'd0);
      tot = 0;
      en_edges = 0;
      seen = 1'b0;
      while (!seen && tot < 400) begin
         // Inputs changing after accept must be ignored.
         in_valid = 1'($urandom);
         den = rand_w();
         for (int k = 0; k < C; k++) num[k*W +: W] = rand_w();
         if (gap_mode == 1) clken = ($urandom % 4) != 0;
         else if (gap_mode == 2) clken = !(tot >= 10 && tot < 13);
         else clken = 1'b1;
         if (clken) en_edges++;
         tot++;
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      in_valid = 1'b0;
      clken = 1'b1;
      check({tag, " out_valid_seen"}, 64'(seen), 64'd1);
      check({tag, " enabled_latency"}, 64'(en_edges), 64'(W + 1));
      if (gap_mode == 0) check({tag, " latency"}, 64'(tot), 64'(W + 1));
      if (gap_mode == 2) check({tag, " latency_gap"}, 64'(tot), 64'(W + 4));
      for (int k = 0; k < C; k++) begin
         check($sformatf("%s quot[%0d]", tag, k), 64'(quot[k*W +: W]), 64'(eq[k*W +: W]));
         check($sformatf("%s rem[%0d]", tag, k), 64'(remain[k*W +: W]), 64'(er[k*W +: W]));
      end
      check({tag, " div_zero"}, 64'(div_zero), 64'(d == '0));
      last_quot = quot;
      last_rem  = remain;
      last_zero = div_zero;
      for (int i = 0; i < bp; i++) begin
         clken = 1'($urandom);
         @(posedge clk);
         #1;
         check({tag, " bp_valid"}, 64'(out_valid), 64'd1);
         check({tag, " bp_stable"}, 64'(quot === eq && remain === er && div_zero === (d == '0)),
               64'd1);
      end
      clken = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, " valid_after_hs"}, 64'(out_valid), 64'd0);
      check({tag, " ready_after_hs"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [W*C-1:0] n;
      logic [W-1:0]   d;
      reset = 1'b0;
      clken = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      den = '0;
      num = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset div_zero", 64'(div_zero), 64'd0);
      check("reset quot_zero", 64'(quot == '0), 64'd1);
      check("reset rem_zero", 64'(remain == '0), 64'd1);
      @(negedge clk);
      reset = 1'b1;

      // Basic division, first enabled edge after reset release.
      for (int k = 0; k < C; k++) n[k*W +: W] = W'(100 + k);
      do_req("basic", W'(7), n, 0, 0);
      check("basic lane0 quot", 64'(last_quot[0 +: W]), 64'd14);
      check("basic lane0 rem", 64'(last_rem[0 +: W]), 64'd2);
      check("basic lane10 quot", 64'(last_quot[10*W +: W]), 64'd15);
      check("basic lane10 rem", 64'(last_rem[10*W +: W]), 64'd5);

      // Divide by zero.
      for (int k = 0; k < C; k++) n[k*W +: W] = rand_w();
      n[3*W +: W] = W'(40'h12345);
      do_req("divzero", '0, n, 0, 0);
      check("divzero lane3 quot", 64'(last_quot[3*W +: W]), 64'hFF_FFFF_FFFF);
      check("divzero lane3 rem", 64'(last_rem[3*W +: W]), 64'h12345);
      check("divzero flag", 64'(last_zero), 64'd1);

      // Backpressure and enable gap.
      for (int k = 0; k < C; k++) n[k*W +: W] = rand_w();
      do_req("backpressure", W'(12345), n, 2, 5);

      // Reset in the middle of RUN.
      den = W'(100);
      num = '1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("midreset out_valid", 64'(out_valid), 64'd0);
      check("midreset in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < C; k++) n[k*W +: W] = rand_w();
      n[0 +: W] = W'(10);
      do_req("after_reset", W'(3), n, 0, 0);
      check("after_reset quot", 64'(last_quot[0 +: W]), 64'd3);
      check("after_reset rem", 64'(last_rem[0 +: W]), 64'd1);

`ifdef PARALLEL_DIVIDER_SIGNED_EN
      for (int k = 0; k < C; k++) n[k*W +: W] = rand_w();
      n[0 +: W] = W'(7);
      do_req("signed", -W'(3), n, 0, 0);
      check("signed quot", 64'(last_quot[0 +: W]), 64'(-W'(2)));
      check("signed rem", 64'(last_rem[0 +: W]), 64'd1);
      n[0 +: W] = W'(40'h80_0000_0000);
      do_req("signed_ovf", '1, n, 0, 0);
      check("signed_ovf quot", 64'(last_quot[0 +: W]), 64'h80_0000_0000);
      check("signed_ovf rem", 64'(last_rem[0 +: W]), 64'd0);
`endif

      // Randomized regression.
      for (int i = 0; i < 150; i++) begin
         case ($urandom % 8)
            0:       d = '0;
            1, 2, 3: d = W'($urandom % 16);
            4:       d = '1;
            default: d = rand_w();
         endcase
         for (int k = 0; k < C; k++) begin
            n[k*W +: W] = ($urandom % 4 == 0) ? W'($urandom % 64) : rand_w();
         end
         do_req($sformatf("rand%0d", i), d, n, int'($urandom % 2), int'($urandom % 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
